// File: rtl/sram_arb_pkg.sv
// Shared types and default sizes for the two-client SRAM port arbiter.
package sram_arb_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DEPTH  = 128;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        DONE
    } arbStateT;

    typedef enum logic {
        CLI_A,
        CLI_B
    } clientT;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Client A/B request buses plus the SRAM register-array drive bundle.
interface sram_port_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;
    logic              a_err;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    logic              b_err;

    logic [ADDR_W-1:0] sram_read_reg;
    logic [ADDR_W-1:0] sram_write_reg;
    logic [DATA_W-1:0] sram_write_data;
    logic              sram_reg_write;
    logic [DATA_W-1:0] sram_read_data;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  sram_read_data,
        output a_ack, a_rdata, a_err,
        output b_ack, b_rdata, b_err,
        output sram_read_reg, sram_write_reg, sram_write_data, sram_reg_write
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output sram_read_data,
        input  a_ack, a_rdata, a_err,
        input  b_ack, b_rdata, b_err,
        input  sram_read_reg, sram_write_reg, sram_write_data, sram_reg_write
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; grant[0] = client A, grant[1] = client B.
module rr_arbiter2
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  clientT     ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (ptr == CLI_A) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Serialises two clients onto the SRAM register array: setup, one-cycle write strobe,
// then a one-cycle ack with registered read data / refusal flag.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DEPTH        = DEF_DEPTH,
    parameter bit          PROTECT_ZERO = 1'b1
) (
    input logic                clk,
    input logic                reset,
    sram_port_arbiter_if.slave bus
);

    arbStateT          stateQ, stateD;
    clientT            ptrQ, ptrD;
    clientT            grantQ, grantD;
    logic              weQ, weD;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic [DATA_W-1:0] wdataQ, wdataD;
    logic              regWriteQ, regWriteD;
    logic [1:0]        ackQ, ackD;
    logic [1:0]        errQ, errD;
    logic [DATA_W-1:0] aRdataQ, aRdataD;
    logic [DATA_W-1:0] bRdataQ, bRdataD;
    logic [1:0]        pick;
    logic              gIdx;
    logic              illegal;

    rr_arbiter2 uArb (
        .req   ({bus.b_req, bus.a_req}),
        .ptr   (ptrQ),
        .grant (pick)
    );

    assign gIdx    = (grantQ == CLI_B);
    assign illegal = (32'(addrQ) >= DEPTH) || (PROTECT_ZERO && weQ && (addrQ == '0));

    always_comb begin
        stateD  = stateQ;
        ptrD    = ptrQ;
        grantD  = grantQ;
        weD     = weQ;
        addrD   = addrQ;
        wdataD  = wdataQ;
        errD    = errQ;
        aRdataD = aRdataQ;
        bRdataD = bRdataQ;
        unique case (stateQ)
            IDLE: begin
                if (pick[1]) begin
                    grantD = CLI_B;
                    weD    = bus.b_we;
                    addrD  = bus.b_addr;
                    wdataD = bus.b_wdata;
                    stateD = SETUP;
                end else if (pick[0]) begin
                    grantD = CLI_A;
                    weD    = bus.a_we;
                    addrD  = bus.a_addr;
                    wdataD = bus.a_wdata;
                    stateD = SETUP;
                end
            end
            SETUP: begin
                if (illegal) begin
                    errD[gIdx] = 1'b1;
                    stateD     = DONE;
                end else if (weQ) begin
                    stateD = STROBE;
                end else begin
                    errD[gIdx] = 1'b0;
                    if (gIdx) bRdataD = bus.sram_read_data;
                    else      aRdataD = bus.sram_read_data;
                    stateD = DONE;
                end
            end
            STROBE: begin
                errD[gIdx] = 1'b0;
                stateD     = DONE;
            end
            DONE: begin
                ptrD   = (grantQ == CLI_A) ? CLI_B : CLI_A;
                stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
        // Registered outputs track the state being entered, so they line up with it.
        ackD       = '0;
        ackD[gIdx] = (stateD == DONE);
        regWriteD  = (stateD == STROBE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ    <= IDLE;
            ptrQ      <= CLI_A;
            grantQ    <= CLI_A;
            weQ       <= 1'b0;
            addrQ     <= '0;
            wdataQ    <= '0;
            regWriteQ <= 1'b0;
            ackQ      <= '0;
            errQ      <= '0;
            aRdataQ   <= '0;
            bRdataQ   <= '0;
        end else begin
            stateQ    <= stateD;
            ptrQ      <= ptrD;
            grantQ    <= grantD;
            weQ       <= weD;
            addrQ     <= addrD;
            wdataQ    <= wdataD;
            regWriteQ <= regWriteD;
            ackQ      <= ackD;
            errQ      <= errD;
            aRdataQ   <= aRdataD;
            bRdataQ   <= bRdataD;
        end
    end

    assign bus.sram_read_reg   = addrQ;
    assign bus.sram_write_reg  = addrQ;
    assign bus.sram_write_data = wdataQ;
    assign bus.sram_reg_write  = regWriteQ;
    assign bus.a_ack           = ackQ[0];
    assign bus.b_ack           = ackQ[1];
    assign bus.a_err           = errQ[0];
    assign bus.b_err           = errQ[1];
    assign bus.a_rdata         = aRdataQ;
    assign bus.b_rdata         = bRdataQ;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised self-checking bench: 128x8 SRAM model plus a transaction-level reference.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sram_port_arbiter_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    sram_port_arbiter #(
        .DATA_W       (8),
        .ADDR_W       (8),
        .DEPTH        (128),
        .PROTECT_ZERO (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // SRAM register array: combinational read, write while regWrite is high.
    logic [7:0] mem [128];
    int         strobeCount = 0;
    logic [7:0] lastStrobeAddr = 8'h00;
    logic [7:0] lastStrobeData = 8'h00;

    assign bus.sram_read_data = (bus.sram_read_reg < 8'd128) ? mem[bus.sram_read_reg[6:0]] : 8'h00;

    always @(posedge clk) begin
        if (bus.sram_reg_write) begin
            strobeCount    <= strobeCount + 1;
            lastStrobeAddr <= bus.sram_write_reg;
            lastStrobeData <= bus.sram_write_data;
            if (bus.sram_write_reg < 8'd128) mem[bus.sram_write_reg[6:0]] <= bus.sram_write_data;
        end
    end

    // Address/data must match the cycle before and after any strobe cycle.
    logic [7:0] prevAddr = 8'h00;
    logic [7:0] prevData = 8'h00;
    logic       prevWr = 1'b0;
    int         stabErr = 0;

    always @(negedge clk) begin
        if (reset) begin
            prevWr <= 1'b0;
        end else begin
            if ((bus.sram_reg_write || prevWr) &&
                (bus.sram_write_reg !== prevAddr || bus.sram_read_reg !== prevAddr ||
                 bus.sram_write_data !== prevData))
                stabErr <= stabErr + 1;
            prevWr <= bus.sram_reg_write;
        end
        prevAddr <= bus.sram_write_reg;
        prevData <= bus.sram_write_data;
    end

    // Reference model
    logic [7:0] refMem [128];
    logic [7:0] refRdata [2];
    logic       refErr [2];
    bit         refPtr;

    function automatic void modelReset();
        refRdata[0] = 8'h00;
        refRdata[1] = 8'h00;
        refErr[0]   = 1'b0;
        refErr[1]   = 1'b0;
        refPtr      = 1'b0;
    endfunction

    function automatic bit isLegal(input bit we, input logic [7:0] addr);
        return (addr < 8'd128) && !(we && addr == 8'd0);
    endfunction

    function automatic void modelTxn(input bit cli, input bit we, input logic [7:0] addr,
                                     input logic [7:0] wdata);
        if (!isLegal(we, addr)) begin
            refErr[cli] = 1'b1;
        end else begin
            refErr[cli] = 1'b0;
            if (we) refMem[addr[6:0]] = wdata;
            else    refRdata[cli] = refMem[addr[6:0]];
        end
        refPtr = !cli;
    endfunction

    task automatic driveClient(input bit cli, input bit req, input bit we,
                               input logic [7:0] addr, input logic [7:0] wdata);
        if (cli) begin
            bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
        end else begin
            bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
        end
    endtask

    task automatic randPayload(output bit we, output logic [7:0] addr, output logic [7:0] wdata);
        int r;
        r     = $urandom_range(0, 9);
        we    = 1'($urandom_range(0, 1));
        wdata = 8'($urandom);
        if (r == 0)      addr = 8'h00;
        else if (r == 1) addr = 8'(128 + $urandom_range(0, 127));
        else             addr = 8'($urandom_range(1, 20));
    endtask

    // Waits (bounded) for an ack; which = 0/1, 2 if both, -1 on timeout.
    task automatic waitAck(output int which);
        which = -1;
        for (int c = 0; c < 12 && which == -1; c++) begin
            @(negedge clk);
            if (bus.a_ack && bus.b_ack) which = 2;
            else if (bus.a_ack)         which = 0;
            else if (bus.b_ack)         which = 1;
        end
    endtask

    task automatic runTxn(input bit cli, input bit we, input logic [7:0] addr,
                          input logic [7:0] wdata);
        int         cyc, sBefore, expLat, expStrobes;
        bit         got, otherAck;
        logic [7:0] rd;
        logic       er;
        expLat     = (isLegal(we, addr) && we) ? 4 : 3;
        expStrobes = (isLegal(we, addr) && we) ? 1 : 0;
        @(negedge clk);
        sBefore = strobeCount;
        driveClient(cli, 1'b1, we, addr, wdata);
        cyc = 1; got = 1'b0; otherAck = 1'b0;
        while (!got && cyc < 12) begin
            @(negedge clk);
            cyc++;
            got = cli ? bus.b_ack : bus.a_ack;
            otherAck |= cli ? bus.a_ack : bus.b_ack;
        end
        rd = cli ? bus.b_rdata : bus.a_rdata;
        er = cli ? bus.b_err : bus.a_err;
        driveClient(cli, 1'b0, 1'b0, 8'h00, 8'h00);
        modelTxn(cli, we, addr, wdata);
        checks++;
        if (!got || cyc != expLat) begin
            errors++;
            $display("FAIL latency cli=%0d we=%0d addr=%02h: ack cycle %0d (seen=%0d) expected %0d",
                     cli, we, addr, cyc, got, expLat);
        end
        checks++;
        if (rd !== refRdata[cli]) begin
            errors++;
            $display("FAIL rdata cli=%0d addr=%02h: got %02h expected %02h", cli, addr, rd,
                     refRdata[cli]);
        end
        checks++;
        if (er !== refErr[cli]) begin
            errors++;
            $display("FAIL err cli=%0d we=%0d addr=%02h: got %0b expected %0b", cli, we, addr, er,
                     refErr[cli]);
        end
        checks++;
        if (strobeCount - sBefore != expStrobes) begin
            errors++;
            $display("FAIL strobes cli=%0d addr=%02h: got %0d expected %0d", cli, addr,
                     strobeCount - sBefore, expStrobes);
        end
        checks++;
        if (otherAck !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack cli=%0d: other client acked, expected no ack", cli);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        driveClient(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        driveClient(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.a_ack, bus.a_err, bus.a_rdata, bus.b_ack, bus.b_err, bus.b_rdata} !== 20'h0) begin
            errors++;
            $display("FAIL reset_client_outputs: got %05h expected 00000",
                     {bus.a_ack, bus.a_err, bus.a_rdata, bus.b_ack, bus.b_err, bus.b_rdata});
        end
        checks++;
        if ({bus.sram_read_reg, bus.sram_write_reg, bus.sram_write_data, bus.sram_reg_write}
            !== 25'h0) begin
            errors++;
            $display("FAIL reset_sram_outputs: got %07h expected 0000000",
                     {bus.sram_read_reg, bus.sram_write_reg, bus.sram_write_data,
                      bus.sram_reg_write});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_contention();
        int         which, sBefore, expStrobes;
        bit         we [2];
        logic [7:0] addr [2];
        logic [7:0] wdata [2];
        @(negedge clk);
        sBefore = strobeCount;
        expStrobes = 2;
        we[0] = 1'b1; addr[0] = 8'h01; wdata[0] = 8'h11;
        we[1] = 1'b1; addr[1] = 8'h02; wdata[1] = 8'h22;
        driveClient(1'b0, 1'b1, we[0], addr[0], wdata[0]);
        driveClient(1'b1, 1'b1, we[1], addr[1], wdata[1]);
        for (int k = 0; k < 2; k++) begin
            waitAck(which);
            checks++;
            if (which !== int'(refPtr)) begin
                errors++;
                $display("FAIL contention_order[%0d]: ack from %0d expected %0d", k, which, refPtr);
            end
            if (which == 0 || which == 1) begin
                modelTxn(which[0], we[which], addr[which], wdata[which]);
                driveClient(which[0], 1'b0, 1'b0, 8'h00, 8'h00);
            end
        end
        runTxn(1'b0, 1'b0, 8'h01, 8'h00);
        runTxn(1'b1, 1'b0, 8'h02, 8'h00);
        // Continuous dual requests: acks must alternate.
        @(negedge clk);
        sBefore = strobeCount;
        expStrobes = 0;
        for (int c = 0; c < 2; c++) begin
            randPayload(we[c], addr[c], wdata[c]);
            driveClient(c[0], 1'b1, we[c], addr[c], wdata[c]);
        end
        for (int k = 0; k < 16; k++) begin
            waitAck(which);
            checks++;
            if (which !== int'(refPtr)) begin
                errors++;
                $display("FAIL alternate[%0d]: ack from %0d expected %0d", k, which, refPtr);
            end
            if (which == 0 || which == 1) begin
                if (isLegal(we[which], addr[which]) && we[which]) expStrobes++;
                modelTxn(which[0], we[which], addr[which], wdata[which]);
                checks++;
                if ((which ? bus.b_rdata : bus.a_rdata) !== refRdata[which] ||
                    (which ? bus.b_err : bus.a_err) !== refErr[which]) begin
                    errors++;
                    $display("FAIL alternate_data[%0d]: rdata %02h err %0b expected %02h %0b", k,
                             which ? bus.b_rdata : bus.a_rdata, which ? bus.b_err : bus.a_err,
                             refRdata[which], refErr[which]);
                end
                randPayload(we[which], addr[which], wdata[which]);
                driveClient(which[0], 1'b1, we[which], addr[which], wdata[which]);
            end
        end
        driveClient(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        driveClient(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        checks++;
        if (strobeCount - sBefore != expStrobes) begin
            errors++;
            $display("FAIL alternate_strobes: got %0d expected %0d", strobeCount - sBefore,
                     expStrobes);
        end
    endtask

    task automatic test_write_read();
        runTxn(1'b0, 1'b1, 8'd5, 8'h3C);
        checks++;
        if (lastStrobeAddr !== 8'd5 || lastStrobeData !== 8'h3C) begin
            errors++;
            $display("FAIL strobe_payload: got addr %02h data %02h expected 05 3c",
                     lastStrobeAddr, lastStrobeData);
        end
        runTxn(1'b0, 1'b0, 8'd5, 8'h00);
    endtask

    task automatic test_protect_zero();
        runTxn(1'b0, 1'b1, 8'h00, 8'hA0);
        runTxn(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_out_of_range();
        runTxn(1'b1, 1'b0, 8'h80, 8'h00);
        runTxn(1'b1, 1'b1, 8'h7F, 8'h55);
        runTxn(1'b1, 1'b0, 8'h7F, 8'h00);
    endtask

    task automatic test_reset_mid_write();
        bit seen;
        bit acked;
        @(negedge clk);
        driveClient(1'b0, 1'b1, 1'b1, 8'd9, 8'h99);
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            seen = bus.sram_reg_write;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midreset_strobe: strobe seen %0b expected 1", seen);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.sram_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL midreset_regwrite: got %0b expected 0", bus.sram_reg_write);
        end
        modelReset();
        acked = 1'b0;
        repeat (2) begin
            @(negedge clk);
            acked |= bus.a_ack | bus.b_ack;
        end
        driveClient(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            acked |= bus.a_ack | bus.b_ack;
        end
        checks++;
        if (acked !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ack: ack seen %0b expected 0", acked);
        end
        checks++;
        if (bus.a_rdata !== 8'h00 || bus.a_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: rdata %02h err %0b expected 00 0", bus.a_rdata,
                     bus.a_err);
        end
        runTxn(1'b0, 1'b1, 8'd9, 8'h99);
        runTxn(1'b0, 1'b0, 8'd9, 8'h00);
    endtask

    task automatic test_random();
        bit         we;
        logic [7:0] addr, wdata;
        for (int k = 0; k < 30; k++) begin
            randPayload(we, addr, wdata);
            runTxn(1'($urandom_range(0, 1)), we, addr, wdata);
        end
    endtask

    task automatic test_sweep();
        int sBefore;
        sBefore = strobeCount;
        for (int i = 1; i < 128; i++) runTxn(1'(i), 1'b1, 8'(i), 8'(i * 3));
        checks++;
        if (strobeCount - sBefore != 127) begin
            errors++;
            $display("FAIL sweep_strobes: got %0d expected 127", strobeCount - sBefore);
        end
        for (int i = 1; i < 128; i++) runTxn(1'(i + 1), 1'b0, 8'(i), 8'h00);
        checks++;
        if (stabErr != 0) begin
            errors++;
            $display("FAIL addr_data_stability: got %0d violations expected 0", stabErr);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i]    = 8'h00;
            refMem[i] = 8'h00;
        end
        test_reset();
        test_contention();
        test_write_read();
        test_protect_zero();
        test_out_of_range();
        test_reset_mid_write();
        test_random();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Two-client round-robin arbiter and access sequencer in front of the 128x8 SRAM register array.
- That array has a combinational read, and its write is level-sensitive on its write-enable input.
- This block serialises client requests and holds address/data stable around a one-cycle write strobe.
- It captures read data, returns a one-cycle ack per transaction, and optionally protects address 0 (hardwired zero register).

Parameters:
- DATA_W, 8, data width of SRAM word and client data
- ADDR_W, 8, SRAM address port width
- DEPTH, 128, number of implemented SRAM entries; addresses >= DEPTH are rejected
- PROTECT_ZERO, 1, when 1, writes to address 0 are refused with err

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- a_req  input  1  client A request; held high until a_ack
- a_we  input  1  client A: 1=write, 0=read; stable while a_req
- a_addr  input  ADDR_W  client A address
- a_wdata  input  DATA_W  client A write data
- a_ack  output  1  one-cycle completion pulse for A
- a_rdata  output  DATA_W  A read data, valid in a_ack cycle
- a_err  output  1  A transaction refused, valid in a_ack cycle
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_err  same as A, for client B
- sram_read_reg  output  ADDR_W  to SRAM readReg
- sram_write_reg  output  ADDR_W  to SRAM writeReg
- sram_write_data  output  DATA_W  to SRAM writeData
- sram_reg_write  output  1  to SRAM regWrite
- sram_read_data  input  DATA_W  from SRAM readData

Behaviour:
- Reset values, applied asynchronously:
  - state=IDLE
  - sram_reg_write=0; all sram_* address/data outputs = 0
  - a/b_ack=0, a/b_err=0, a/b_rdata=0
  - priority pointer -> A
- All outputs are registered.
- FSM states: IDLE, SETUP, STROBE, DONE.
- IDLE:
  - If any req is high, grant one client: if both are high, the pointer client wins; if one is high, that client wins.
  - Latch we/addr/wdata of the winner.
  - Drive sram_read_reg = sram_write_reg = addr and sram_write_data = wdata; go to SETUP.
- SETUP (one cycle, sram_reg_write=0):
  - Illegal request (addr >= DEPTH, or PROTECT_ZERO=1 with a write to addr 0): err=1, no strobe, go to DONE.
  - Legal read: capture sram_read_data into the granted client's rdata, go to DONE.
  - Legal write: go to STROBE.
- STROBE (one cycle): sram_reg_write=1; address/data held unchanged; go to DONE.
- DONE:
  - Granted ack=1 for exactly one cycle; sram_reg_write=0; address/data still held.
  - Pointer moves to the other client.
  - Return to IDLE.
- Latency from the req-sampled edge to ack: reads 3 cycles, writes 4 cycles, refused requests 3 cycles.
- Clients drop req in the cycle after ack. A req still high in IDLE is treated as a new transaction.
- Fairness: with both clients requesting continuously, grants alternate A, B, A, B.
- rdata and err hold their value until the next ack to that client. err is cleared on the next legal ack.
- Request changes after grant are ignored; the latched copy is used.
- Reset mid-operation: sram_reg_write drops in the same instant, the in-flight transaction is dropped with no ack, and the FSM returns to IDLE.
- Address/data never change while sram_reg_write=1: setup and hold each get at least one full cycle.

Decomposition:
- Package sram_arb_pkg:
  - state enum: IDLE, SETUP, STROBE, DONE
  - client index enum: CLI_A, CLI_B
  - localparams for default widths/depth
- One sub-module, rr_arbiter2: combinational 2-way round-robin pick from req[1:0] and the pointer, producing a one-hot grant.
- The top level holds the FSM, request latch and SRAM drive registers.

Test Plan:
- Write then read, A: A writes addr 5 data 0x3C -> sram_reg_write high exactly one cycle with write_reg=5 and data=0x3C stable before, during and after; a_ack at cycle 4. A reads addr 5 -> a_rdata=0x3C with a_ack at cycle 3.
- Contention: A and B both request at reset exit (A write addr 1=0x11, B write addr 2=0x22, held high) -> A acks first, then B. Subsequent reads return 0x11 and 0x22. Continuous dual requests yield alternating acks.
- Protect zero: A writes addr 0 data 0xA0 -> no regWrite pulse, a_ack with a_err=1. A then reads addr 0 -> a_rdata=0x00, a_err=0.
- Out of range: B reads addr 0x80 -> b_err=1 on ack, no SRAM access change. B reads addr 0x7F after writing 0x55 -> 0x55.
- Reset mid-write: assert reset during STROBE -> sram_reg_write=0 immediately, no ack, state IDLE. A re-issued request completes normally.
- Sweep: write addr i = i*3 for i=1..127 via alternating clients, then read back all -> every value matches, 127 write strobes counted.
